fetch_pc_unit: RTL and testbench

- Instruction-fetch and program-counter stage; sits directly upstream of the instruction decoder.
- Owns the PC register and issues fetches to instruction memory. Presents each fetched 16-bit instruction to the decoder for exactly one execute cycle.
- Consumes the decoder's branch select (BS), branch offset (OFF) and HALT, plus the ALU Z/N flags, to compute the next PC or enter the halted state.

---
 rtl/cpu_pkg.sv | 21 ++
 rtl/next_pc_logic.sv | 33 +++
 rtl/fetch_pc_unit.sv | 112 +++++++++++
 tb/tb_fetch_pc_unit.sv | 414 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared constants and types for the fetch/PC stage and its neighbours.
package cpu_pkg;

    localparam int INST_W = 16;
    localparam int OFF_W  = 6;

    localparam logic [2:0] BS_Z    = 3'b000;
    localparam logic [2:0] BS_NZ   = 3'b001;
    localparam logic [2:0] BS_NN   = 3'b010;
    localparam logic [2:0] BS_N    = 3'b011;
    localparam logic [2:0] BS_NONE = 3'b100;

    localparam logic [INST_W-1:0] NOP = 16'h0000;

    typedef enum logic [1:0] {
        StFetch  = 2'b00,
        StExec   = 2'b01,
        StHalted = 2'b10
    } fetch_state_e;

endpackage

// File: rtl/next_pc_logic.sv
// Combinational branch decision and next-PC computation for one executed instruction.
module next_pc_logic
    import cpu_pkg::*;
#(
    parameter int unsigned PC_W = 8
) (
    input  logic [PC_W-1:0]  pc,
    input  logic [2:0]       bs,
    input  logic [OFF_W-1:0] off,
    input  logic             z,
    input  logic             n,
    output logic [PC_W-1:0]  next_pc,
    output logic             taken
);

    logic [PC_W-1:0] off_ext;

    always_comb begin
        taken = 1'b0;
        case (bs)
            BS_Z:    taken = z;
            BS_NZ:   taken = ~z;
            BS_NN:   taken = ~n;
            BS_N:    taken = n;
            default: taken = 1'b0;
        endcase
    end

    assign off_ext = PC_W'($signed(off));
    // Relative to the following word; wraps modulo 2^PC_W.
    assign next_pc = pc + PC_W'(1) + (taken ? off_ext : '0);

endmodule

// File: rtl/fetch_pc_unit.sv
// Fetch / program-counter stage: FETCH -> EXEC -> FETCH, with a HALTED park state.
// Optional INSTRET_COUNT_EN adds a retired-instruction counter output.
module fetch_pc_unit
    import cpu_pkg::*;
#(
    parameter int unsigned PC_W     = 8,
    parameter int unsigned RESET_PC = 0
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req,
    output logic [PC_W-1:0]   imem_addr,
    input  logic [INST_W-1:0] imem_rdata,
    input  logic              imem_valid,
    output logic [INST_W-1:0] inst,
    output logic              inst_valid,
    output logic [PC_W-1:0]   pc,
    input  logic [2:0]        bs,
    input  logic [OFF_W-1:0]  off,
    input  logic              halt,
    input  logic              z,
    input  logic              n,
    input  logic              resume,
    output logic              halted
`ifdef INSTRET_COUNT_EN
    ,
    output logic [15:0]       instret
`endif
);

    fetch_state_e      state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [INST_W-1:0] inst_q, inst_d;
    logic [PC_W-1:0]   branch_pc;
    logic              branch_taken;

    next_pc_logic #(
        .PC_W(PC_W)
    ) u_next_pc (
        .pc     (pc_q),
        .bs     (bs),
        .off    (off),
        .z      (z),
        .n      (n),
        .next_pc(branch_pc),
        .taken  (branch_taken)
    );

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        inst_d  = inst_q;
        case (state_q)
            StFetch: begin
                if (imem_valid) begin
                    inst_d  = imem_rdata;
                    state_d = StExec;
                end
            end
            StExec: begin
                // Halt leaves PC on the halt word; the branch result is discarded.
                if (halt) begin
                    state_d = StHalted;
                end else begin
                    pc_d    = branch_pc;
                    state_d = StFetch;
                end
            end
            StHalted: begin
                if (resume) begin
                    pc_d    = pc_q + PC_W'(1);
                    state_d = StFetch;
                end
            end
            default: state_d = StFetch;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StFetch;
            pc_q    <= PC_W'(RESET_PC);
            inst_q  <= NOP;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            inst_q  <= inst_d;
        end
    end

`ifdef INSTRET_COUNT_EN
    logic [15:0] instret_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            instret_q <= '0;
        end else if (state_q == StExec) begin
            instret_q <= instret_q + 16'd1;
        end
    end

    assign instret = instret_q;
`endif

    assign imem_req   = (state_q == StFetch) && !rst;
    assign imem_addr  = pc_q;
    assign pc         = pc_q;
    assign inst       = inst_q;
    assign inst_valid = (state_q == StExec);
    assign halted     = (state_q == StHalted);

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Randomized self-checking bench for fetch_pc_unit against a PC/branch reference model.
module tb_fetch_pc_unit;

    localparam int PCW = 8;
    localparam int MOD = 1 << PCW;

    logic           clk;
    logic           rst;
    logic           imem_req;
    logic [PCW-1:0] imem_addr;
    logic [15:0]    imem_rdata;
    logic           imem_valid;
    logic [15:0]    inst;
    logic           inst_valid;
    logic [PCW-1:0] pc;
    logic [2:0]     bs;
    logic [5:0]     off;
    logic           halt;
    logic           z;
    logic           n;
    logic           resume;
    logic           halted;
`ifdef INSTRET_COUNT_EN
    logic [15:0]    instret;
`endif

    logic [15:0] mem [MOD];
    int total;
    int bad;
    int exp_pc;
    int exp_instret;

    fetch_pc_unit #(
        .PC_W    (PCW),
        .RESET_PC(0)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .imem_req  (imem_req),
        .imem_addr (imem_addr),
        .imem_rdata(imem_rdata),
        .imem_valid(imem_valid),
        .inst      (inst),
        .inst_valid(inst_valid),
        .pc        (pc),
        .bs        (bs),
        .off       (off),
        .halt      (halt),
        .z         (z),
        .n         (n),
        .resume    (resume),
        .halted    (halted)
`ifdef INSTRET_COUNT_EN
        ,
        .instret   (instret)
`endif
    );

    assign imem_rdata = mem[imem_addr];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: branch conditions evaluated directly from the flag rules.
    function automatic int model_next(int p, logic [2:0] b, logic [5:0] o, logic zz, logic nn);
        bit t;
        int d;
        case (b)
            3'd0:    t = zz;
            3'd1:    t = !zz;
            3'd2:    t = !nn;
            3'd3:    t = nn;
            default: t = 1'b0;
        endcase
        d = o[5] ? int'(o) - 64 : int'(o);
        return t ? (((p + 1 + d) % MOD) + MOD) % MOD : (p + 1) % MOD;
    endfunction

    // Runs one instruction: waits memory cycles, then one EXEC with the given decoder inputs.
    task automatic do_instr(input int waits, input logic [2:0] b, input logic [5:0] o,
                            input logic zz, input logic nn, input logic hh,
                            output int req_cnt, output int iv_cnt, output logic [15:0] inst_seen);
        req_cnt = 0;
        iv_cnt  = 0;
        for (int w = 0; w <= waits; w++) begin
            imem_valid = (w == waits);
            if (imem_req) req_cnt++;
            if (inst_valid) iv_cnt++;
            step();
        end
        imem_valid = 1'b0;
        if (inst_valid) iv_cnt++;
        inst_seen = inst;
        bs = b; off = o; z = zz; n = nn; halt = hh;
        step();
        if (inst_valid) iv_cnt++;
        halt = 1'b0; bs = 3'd4; off = '0;
        exp_instret++;
        if (!hh) exp_pc = model_next(exp_pc, b, o, zz, nn);
    endtask

    task automatic goto_pc(input int target);
        int d;
        int r;
        int v;
        logic [15:0] s;
        for (int k = 0; k < 20 && exp_pc != target; k++) begin
            d = (((target - exp_pc - 1) % MOD) + MOD) % MOD;
            if (d >= MOD / 2) d -= MOD;
            if (d > 31) d = 31;
            if (d < -32) d = -32;
            do_instr(0, 3'd0, 6'(d), 1'b1, 1'b0, 1'b0, r, v, s);
        end
        total++;
        if (pc !== 8'(exp_pc)) begin
            bad++;
            $display("FAIL goto pc got %0d want %0d", pc, exp_pc);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        total++;
        if (pc !== 8'd0 || inst !== 16'h0000) begin
            bad++;
            $display("FAIL reset_regs pc/inst got %0d/%h want 0/0000", pc, inst);
        end
        total++;
        if (inst_valid !== 1'b0 || halted !== 1'b0 || imem_req !== 1'b0) begin
            bad++;
            $display("FAIL reset_flags iv/halted/req got %b%b%b want 000",
                     inst_valid, halted, imem_req);
        end
        rst = 1'b0;
        #1;
        total++;
        if (imem_req !== 1'b1 || imem_addr !== 8'd0) begin
            bad++;
            $display("FAIL reset_release req/addr got %b/%0d want 1/0", imem_req, imem_addr);
        end
        exp_pc = 0;
        exp_instret = 0;
    endtask

    task automatic test_sequential();
        imem_valid = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            total++;
            if (imem_addr !== 8'((k - 1) / 2) || inst_valid !== (k % 2 == 0)) begin
                bad++;
                $display("FAIL seq_cycle%0d addr/iv got %0d/%b want %0d/%b",
                         k, imem_addr, inst_valid, (k - 1) / 2, (k % 2 == 0));
            end
            if (k % 2 == 0) begin
                total++;
                if (inst !== mem[(k - 1) / 2]) begin
                    bad++;
                    $display("FAIL seq_inst%0d got %h want %h", k, inst, mem[(k - 1) / 2]);
                end
            end
            step();
        end
        imem_valid = 1'b0;
        exp_pc = 3;
        exp_instret += 3;
        total++;
        if (pc !== 8'd3) begin
            bad++;
            $display("FAIL seq_end pc got %0d want 3", pc);
        end
    endtask

    task automatic test_wait_states();
        int r;
        int v;
        int p;
        logic [15:0] s;
        for (int i = 0; i < 3; i++) begin
            p = exp_pc;
            do_instr(3, 3'd4, 6'd0, 1'b0, 1'b0, 1'b0, r, v, s);
            total++;
            if (r != 4 || v != 1) begin
                bad++;
                $display("FAIL wait_req_iv got %0d/%0d want 4/1", r, v);
            end
            total++;
            if (s !== mem[p] || pc !== 8'(exp_pc)) begin
                bad++;
                $display("FAIL wait_inst_pc got %h/%0d want %h/%0d", s, pc, mem[p], exp_pc);
            end
        end
    endtask

    task automatic test_branch();
        int r;
        int v;
        logic [15:0] s;
        goto_pc(10);
        do_instr(0, 3'd0, 6'b111100, 1'b1, 1'b0, 1'b0, r, v, s);
        total++;
        if (pc !== 8'd7 || imem_addr !== 8'd7 || exp_pc != 7) begin
            bad++;
            $display("FAIL branch_taken pc/addr got %0d/%0d want 7", pc, imem_addr);
        end
        goto_pc(10);
        do_instr(0, 3'd0, 6'b111100, 1'b0, 1'b0, 1'b0, r, v, s);
        total++;
        if (pc !== 8'd11 || imem_addr !== 8'd11) begin
            bad++;
            $display("FAIL branch_not_taken pc/addr got %0d/%0d want 11", pc, imem_addr);
        end
    endtask

    task automatic test_wrap();
        int r;
        int v;
        logic [15:0] s;
        goto_pc(255);
        do_instr(0, 3'd4, 6'd0, 1'b0, 1'b0, 1'b0, r, v, s);
        total++;
        if (pc !== 8'd0) begin
            bad++;
            $display("FAIL wrap_up pc got %0d want 0", pc);
        end
        goto_pc(2);
        do_instr(0, 3'd3, 6'b111000, 1'b0, 1'b1, 1'b0, r, v, s);
        total++;
        if (pc !== 8'd251) begin
            bad++;
            $display("FAIL wrap_down pc got %0d want 251", pc);
        end
    endtask

    task automatic test_halt();
        int r;
        int v;
        logic [15:0] s;
        int frozen_errs;
        goto_pc(5);
        resume = 1'b1;
        do_instr(0, 3'd4, 6'd0, 1'b0, 1'b0, 1'b0, r, v, s);
        resume = 1'b0;
        total++;
        if (pc !== 8'd6 || halted !== 1'b0) begin
            bad++;
            $display("FAIL resume_running pc/halted got %0d/%b want 6/0", pc, halted);
        end
        goto_pc(5);
        // Halt wins over a taken branch.
        do_instr(0, 3'd0, 6'd3, 1'b1, 1'b0, 1'b1, r, v, s);
        frozen_errs = 0;
        imem_valid = 1'b1;
        for (int k = 0; k < 10; k++) begin
            bs = 3'($urandom_range(0, 7));
            z = 1'($urandom);
            if (halted !== 1'b1 || imem_req !== 1'b0 || pc !== 8'd5 || inst_valid !== 1'b0)
                frozen_errs++;
            step();
        end
        imem_valid = 1'b0;
        bs = 3'd4;
        total++;
        if (frozen_errs != 0) begin
            bad++;
            $display("FAIL halt_hold bad_cycles got %0d want 0 (pc=%0d halted=%b)",
                     frozen_errs, pc, halted);
        end
        resume = 1'b1;
        step();
        resume = 1'b0;
        exp_pc = 6;
        total++;
        if (halted !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 8'd6) begin
            bad++;
            $display("FAIL resume halted/req/addr got %b/%b/%0d want 0/1/6",
                     halted, imem_req, imem_addr);
        end
    endtask

    task automatic test_random();
        int r;
        int v;
        int p;
        int w;
        logic [15:0] s;
        logic [2:0] b;
        for (int i = 0; i < 40; i++) begin
            p = exp_pc;
            w = $urandom_range(0, 2);
            b = 3'($urandom_range(0, 7));
            do_instr(w, b, 6'($urandom), 1'($urandom), 1'($urandom), 1'b0, r, v, s);
            total++;
            if (pc !== 8'(exp_pc) || r != w + 1 || v != 1 || s !== mem[p]) begin
                bad++;
                $display("FAIL random%0d pc/req/iv/inst got %0d/%0d/%0d/%h want %0d/%0d/1/%h",
                         i, pc, r, v, s, exp_pc, w + 1, mem[p]);
            end
        end
    endtask

    task automatic test_reset_mid();
        int r;
        int v;
        logic [15:0] s;
        goto_pc(9);
        imem_valid = 1'b0;
        step();
        step();
        total++;
        if (imem_req !== 1'b1 || imem_addr !== 8'd9) begin
            bad++;
            $display("FAIL midreset_pre req/addr got %b/%0d want 1/9", imem_req, imem_addr);
        end
        rst = 1'b1;
        step();
        total++;
        if (pc !== 8'd0 || inst !== 16'h0000 || inst_valid !== 1'b0 || imem_req !== 1'b0) begin
            bad++;
            $display("FAIL midreset pc/inst/iv/req got %0d/%h/%b/%b want 0/0000/0/0",
                     pc, inst, inst_valid, imem_req);
        end
        rst = 1'b0;
        #1;
        exp_pc = 0;
        exp_instret = 0;
        total++;
        if (imem_req !== 1'b1 || imem_addr !== 8'd0) begin
            bad++;
            $display("FAIL midreset_restart req/addr got %b/%0d want 1/0", imem_req, imem_addr);
        end
`ifdef INSTRET_COUNT_EN
        total++;
        if (instret !== 16'd0) begin
            bad++;
            $display("FAIL midreset_instret got %0d want 0", instret);
        end
`endif
        do_instr(1, 3'd4, 6'd0, 1'b0, 1'b0, 1'b1, r, v, s);
        total++;
        if (halted !== 1'b1) begin
            bad++;
            $display("FAIL halt_before_reset got %b want 1", halted);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        exp_pc = 0;
        exp_instret = 0;
        total++;
        if (halted !== 1'b0 || imem_req !== 1'b1 || pc !== 8'd0) begin
            bad++;
            $display("FAIL reset_exits_halt halted/req/pc got %b/%b/%0d want 0/1/0",
                     halted, imem_req, pc);
        end
    endtask

    task automatic test_instret();
`ifdef INSTRET_COUNT_EN
        total++;
        if (instret !== 16'(exp_instret)) begin
            bad++;
            $display("FAIL instret got %0d want %0d", instret, exp_instret);
        end
`endif
    endtask

    initial begin
        total = 0;
        bad = 0;
        exp_pc = 0;
        exp_instret = 0;
        for (int i = 0; i < MOD; i++) mem[i] = 16'($urandom) | 16'h0001;
        rst = 1'b1;
        imem_valid = 1'b0;
        bs = 3'd4;
        off = '0;
        halt = 1'b0;
        z = 1'b0;
        n = 1'b0;
        resume = 1'b0;

        test_reset();
        test_instret();
        test_sequential();
        test_wait_states();
        test_branch();
        test_wrap();
        test_halt();
        test_instret();
        test_random();
        test_instret();
        test_reset_mid();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
